dw_line_buffer: RTL and testbench
=================================

// Module: dw_line_buffer
// PURPOSE
//  K-row sliding line buffer for the depthwise conv path. Stores K-1 previous rows of CH_NUM-channel pixels
//  in one dual-port RAM; emits a K-tall column per accepted pixel to the K×K window stage.
//  Generalises the fixed 3-row buffer: parametric K/channels/depth, runtime row length, warm-up suppression, position flags.
// PARAMETERS
//  DATA_WIDTH   8                      bits per channel sample
//  CH_NUM       18                     channels carried in parallel
//  KERNEL       3                      rows per output column (>=2)
//  MAX_ROW_LEN  320                    max pixels per row = RAM depth
//  ADDR_W       $clog2(MAX_ROW_LEN)    column counter / RAM address width
// PORTS
//  clk        in   1                         single clock; all logic rising edge
//  rstn       in   1                         asynchronous, active-low reset
//  cfg_load   in   1                         pulse: latch row_len, restart frame (sync clear)
//  row_len    in   ADDR_W+1                  pixels per row, sampled on cfg_load; legal 2..MAX_ROW_LEN
//  data_in    in   CH_NUM*DATA_WIDTH         current-row pixel, ch0 in LSBs
//  valid_in   in   1                         data_in qualifier; no backpressure
//  data_out   out  KERNEL*CH_NUM*DATA_WIDTH  {row t-(K-1) .. row t-1, row t}; current row in LSBs
//  valid_out  out  1                         data_out qualifier
//  col_last   out  1                         with valid_out: column row_len-1
//  row_first  out  1                         with valid_out: first emitted row of frame
// BEHAVIOUR
//  - Reset: data_out=0, valid_out=0, col_last=0, row_first=0, col=0, row_cnt=0, row_len_q=MAX_ROW_LEN.
//    RAM contents not reset; warm-up suppression hides stale data. Mid-frame reset drops the in-flight beat.
//  - cfg_load: row_len_q<=row_len (values <2 or >MAX_ROW_LEN clamp to MAX_ROW_LEN); col=0, row_cnt=0,
//    pipeline valid cleared. cfg_load and valid_in same cycle: cfg_load wins, beat dropped.
//  - Counters advance only on accepted beat (valid_in & !cfg_load). col wraps at row_len_q-1 -> 0;
//    on wrap row_cnt increments, saturating at KERNEL-1.
//  - Stage 0 (cycle t, valid_in): RAM rd_addr=col; register data_in, col, col==row_len_q-1, row_cnt.
//  - Stage 1 (cycle t+1): rd_data = K-1 stored rows at that column.
//    data_out <= {rd_data, data_in_d}; valid_out <= v_d & (row_cnt_d==KERNEL-1).
//    RAM write at col_d: {rd_data minus oldest row, data_in_d} (shift up one row). Write every accepted beat, incl. warm-up.
//  - Latency: valid_in -> valid_out exactly 2 cycles, fixed; outputs registered.
//  - Gaps in valid_in allowed anywhere; no state moves on idle cycles.
//  - RAM hazard: with row_len_q>=2 the write (col_d) and read (col) addresses never coincide on
//    back-to-back beats; no bypass needed. RAM is read-first, 1-cycle synchronous read.
//  - Warm-up: first KERNEL-1 rows of a frame produce no valid_out. row_first marks first emitted row,
//    col_last marks last column, both qualified by valid_out, 0 otherwise.
//  - Frame end is implicit: next frame starts with cfg_load; without it rows keep streaming (continuous valid_out).
// STRUCTURE
//  - Shared pkg constants: DW_DATA_WIDTH, DW_CH_NUM, DW_KERNEL, DW_MAX_ROW_LEN; function clamp_row_len().
//  - One sub-module: dw_line_ram (simple dual-port, width (KERNEL-1)*CH_NUM*DATA_WIDTH, depth MAX_ROW_LEN,
//    read-first, sync read, no reset); vendor DRM or inferred behind it.
//  - Top: column/row counters, 2-stage pipeline, shift-pack of write word, flag generation.
// TESTING (K=3, CH_NUM=2, DATA_WIDTH=8 unless stated)
//  - Warm-up: cfg_load row_len=4, stream 12 pixels value=index -> valid_out only for pixels 8..11;
//    pixel 8 out = {0,4,8} per channel, row_first=1 for 8..11, col_last=1 at pixel 11.
//  - Latency/gaps: insert random 0-3 idle cycles between beats -> each valid_out exactly 2 cycles after its valid_in, data identical to gapless run.
//  - Wrap and saturate: row_len=320, 5 rows -> rows 2..4 emitted, col_last every 320th output, row_first only on row 2.
//  - Reconfigure: mid-frame cfg_load row_len=5 with coincident valid_in -> beat dropped, next 10 beats silent, valid_out from beat 11.
//  - Clamp/reset: row_len=0 -> behaves as 320; assert rstn low mid-row -> all outputs 0 next edge, restart warms up again.
//  - Scaling: K=5, CH_NUM=4, row_len=7 scoreboard vs reference model over 3 frames -> zero mismatches.

Source files
------------

// File: rtl/dw_line_buffer_pkg.sv
// dw_line_buffer_pkg: shared defaults and row-length helper for the depthwise line buffer.
// Contents: DW_* default geometry constants, clamp_row_len() maps illegal row lengths to the maximum.
package dw_line_buffer_pkg;

   localparam int DW_DATA_WIDTH  = 8;
   localparam int DW_CH_NUM      = 18;
   localparam int DW_KERNEL      = 3;
   localparam int DW_MAX_ROW_LEN = 320;

   // Row lengths below 2 would let the RAM read and write addresses collide, so they fall back to max.
   function automatic int clamp_row_len(input int len, input int max_len);
      return (len < 2 || len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/dw_line_buffer_if.sv
// dw_line_buffer_if: configuration, pixel-in and column-out signals of the line buffer.
// Master drives cfg_load/row_len/data_in/valid_in; slave drives data_out/valid_out/col_last/row_first.
interface dw_line_buffer_if #(
   parameter int DATA_WIDTH  = dw_line_buffer_pkg::DW_DATA_WIDTH,
   parameter int CH_NUM      = dw_line_buffer_pkg::DW_CH_NUM,
   parameter int KERNEL      = dw_line_buffer_pkg::DW_KERNEL,
   parameter int MAX_ROW_LEN = dw_line_buffer_pkg::DW_MAX_ROW_LEN,
   parameter int ADDR_W      = $clog2(MAX_ROW_LEN)
);

   logic                                cfg_load;
   logic [ADDR_W:0]                     row_len;
   logic [CH_NUM*DATA_WIDTH-1:0]        data_in;
   logic                                valid_in;
   logic [KERNEL*CH_NUM*DATA_WIDTH-1:0] data_out;
   logic                                valid_out;
   logic                                col_last;
   logic                                row_first;

   modport master (
      output cfg_load, row_len, data_in, valid_in,
      input  data_out, valid_out, col_last, row_first
   );

   modport slave (
      input  cfg_load, row_len, data_in, valid_in,
      output data_out, valid_out, col_last, row_first
   );

endinterface

// File: rtl/dw_line_ram.sv
// dw_line_ram: simple dual-port RAM holding K-1 previous rows per column; read-first, 1-cycle sync read.
// Ports: clk, i_we/i_waddr/i_wdata write port, i_raddr read address, o_rdata registered read data.
// Contents are not reset.
module dw_line_ram #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 320,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Read sees the pre-write contents on a same-address collision.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/dw_line_buffer.sv
// dw_line_buffer: K-row sliding line buffer; emits a K-tall column per accepted pixel after warm-up.
// Ports: clk, rstn (async active-low), bus (slave): cfg_load/row_len restart a frame,
//        data_in/valid_in pixel stream, data_out/valid_out column {oldest..current}, col_last/row_first flags.
module dw_line_buffer
   import dw_line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH  = DW_DATA_WIDTH,
   parameter int CH_NUM      = DW_CH_NUM,
   parameter int KERNEL      = DW_KERNEL,
   parameter int MAX_ROW_LEN = DW_MAX_ROW_LEN,
   parameter int ADDR_W      = $clog2(MAX_ROW_LEN)
) (
   input  logic            clk,
   input  logic            rstn,
   dw_line_buffer_if.slave bus
);

   localparam int PIX_W = CH_NUM * DATA_WIDTH;
   localparam int MEM_W = (KERNEL - 1) * PIX_W;
   localparam int RC_W  = $clog2(KERNEL);
   localparam logic [RC_W-1:0] ROW_FULL = RC_W'(KERNEL - 1);

   logic [ADDR_W:0]       r_row_len;
   logic [ADDR_W-1:0]     r_col;
   logic [RC_W-1:0]       r_row_cnt;
   logic                  r_past_first;
   logic                  r_v_d;
   logic [PIX_W-1:0]      r_data_d;
   logic [ADDR_W-1:0]     r_col_d;
   logic                  r_last_d;
   logic                  r_full_d;
   logic                  r_first_d;
   logic [KERNEL*PIX_W-1:0] r_data_out;
   logic                  r_valid_out;
   logic                  r_col_last;
   logic                  r_row_first;
   logic [MEM_W-1:0]      w_rd_data;
   logic [MEM_W-1:0]      w_wr_data;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_full;
   logic                  w_emit;

   assign w_accept = bus.valid_in & ~bus.cfg_load;
   assign w_last   = {1'b0, r_col} == r_row_len - (ADDR_W+1)'(1);
   assign w_full   = r_row_cnt == ROW_FULL;
   // A beat leaving stage 1 while cfg_load is high belongs to the old frame and is discarded.
   assign w_emit   = r_v_d & r_full_d & ~bus.cfg_load;

   // Column/row position; r_past_first records that the first emitted row has completed.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_row_len    <= (ADDR_W+1)'(MAX_ROW_LEN);
         r_col        <= '0;
         r_row_cnt    <= '0;
         r_past_first <= 1'b0;
      end else if (bus.cfg_load) begin
         r_row_len    <= (ADDR_W+1)'(clamp_row_len(int'(bus.row_len), MAX_ROW_LEN));
         r_col        <= '0;
         r_row_cnt    <= '0;
         r_past_first <= 1'b0;
      end else if (bus.valid_in) begin
         r_col <= w_last ? '0 : r_col + ADDR_W'(1);
         if (w_last && !w_full) r_row_cnt <= r_row_cnt + RC_W'(1);
         if (w_last && w_full) r_past_first <= 1'b1;
      end
   end

   // Stage 0: capture the beat while the RAM reads the stored column at r_col.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_v_d     <= 1'b0;
         r_data_d  <= '0;
         r_col_d   <= '0;
         r_last_d  <= 1'b0;
         r_full_d  <= 1'b0;
         r_first_d <= 1'b0;
      end else begin
         r_v_d <= w_accept;
         if (w_accept) begin
            r_data_d  <= bus.data_in;
            r_col_d   <= r_col;
            r_last_d  <= w_last;
            r_full_d  <= w_full;
            r_first_d <= w_full & ~r_past_first;
         end
      end
   end

   // Stage 1: column out is {stored rows, current pixel}.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_data_out  <= '0;
         r_valid_out <= 1'b0;
         r_col_last  <= 1'b0;
         r_row_first <= 1'b0;
      end else begin
         r_valid_out <= w_emit;
         r_col_last  <= w_emit & r_last_d;
         r_row_first <= w_emit & r_first_d;
         if (r_v_d) r_data_out <= {w_rd_data, r_data_d};
      end
   end

   // Write-back drops the oldest row (MSBs) and appends the current pixel in the LSBs.
   generate
      if (KERNEL > 2) begin : g_shift
         assign w_wr_data = {w_rd_data[MEM_W-PIX_W-1:0], r_data_d};
      end else begin : g_single
         assign w_wr_data = r_data_d;
      end
   endgenerate

   // Write lands on r_col_d while the next beat reads r_col; they differ whenever row_len >= 2.
   dw_line_ram #(
      .WIDTH (MEM_W),
      .DEPTH (MAX_ROW_LEN),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk    (clk),
      .i_we   (r_v_d),
      .i_waddr(r_col_d),
      .i_wdata(w_wr_data),
      .i_raddr(r_col),
      .o_rdata(w_rd_data)
   );

   assign bus.data_out  = r_data_out;
   assign bus.valid_out = r_valid_out;
   assign bus.col_last  = r_col_last;
   assign bus.row_first = r_row_first;

endmodule

// File: tb/tb_dw_line_buffer.sv
// tb_dw_line_buffer: drives two line buffers (K=3/CH=2 and K=5/CH=4) with shared stimulus, scoreboards both.
module tb_dw_line_buffer;

   localparam int PA = 16;
   localparam int PB = 32;

   typedef struct {
      logic [159:0] d;
      logic         cl;
      logic         rf;
      int           cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cfg_load = 1'b0;
   logic        valid_in = 1'b0;
   logic [9:0]  row_len = '0;
   logic [31:0] data_in = '0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   logic [31:0] fr [int];
   int          len_q = 320;
   int          m_col = 0;
   int          m_row = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dw_line_buffer_if #(.DATA_WIDTH(8), .CH_NUM(2), .KERNEL(3), .MAX_ROW_LEN(320)) ifa ();
   dw_line_buffer_if #(.DATA_WIDTH(8), .CH_NUM(4), .KERNEL(5), .MAX_ROW_LEN(320)) ifb ();

   assign ifa.cfg_load = cfg_load;
   assign ifa.row_len  = row_len;
   assign ifa.valid_in = valid_in;
   assign ifa.data_in  = data_in[15:0];
   assign ifb.cfg_load = cfg_load;
   assign ifb.row_len  = row_len;
   assign ifb.valid_in = valid_in;
   assign ifb.data_in  = data_in;

   dw_line_buffer #(.DATA_WIDTH(8), .CH_NUM(2), .KERNEL(3), .MAX_ROW_LEN(320)) u_a (
      .clk(clk), .rstn(rstn), .bus(ifa)
   );
   dw_line_buffer #(.DATA_WIDTH(8), .CH_NUM(4), .KERNEL(5), .MAX_ROW_LEN(320)) u_b (
      .clk(clk), .rstn(rstn), .bus(ifb)
   );

   // Advance to the next falling edge and retire any column the DUTs present there.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (!rstn) return;
      if (ifa.valid_out) begin
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected cyc=%0d got data_out=%h required no valid_out", cyc, ifa.data_out);
         end else begin
            e = qa.pop_front();
            if (ifa.data_out !== e.d[47:0] || ifa.col_last !== e.cl || ifa.row_first !== e.rf || cyc != e.cyc) begin
               errors++;
               $display("FAIL a_column got cyc=%0d data=%h cl=%b rf=%b required cyc=%0d data=%h cl=%b rf=%b",
                        cyc, ifa.data_out, ifa.col_last, ifa.row_first, e.cyc, e.d[47:0], e.cl, e.rf);
            end
         end
      end else begin
         checks++;
         if (ifa.col_last !== 1'b0 || ifa.row_first !== 1'b0) begin
            errors++;
            $display("FAIL a_idle_flags cyc=%0d got cl=%b rf=%b required 0 0", cyc, ifa.col_last, ifa.row_first);
         end
         if (qa.size() != 0 && qa[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL a_missing cyc=%0d got no valid_out required data=%h", cyc, qa[0].d[47:0]);
            void'(qa.pop_front());
         end
      end
      if (ifb.valid_out) begin
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected cyc=%0d got data_out=%h required no valid_out", cyc, ifb.data_out);
         end else begin
            e = qb.pop_front();
            if (ifb.data_out !== e.d || ifb.col_last !== e.cl || ifb.row_first !== e.rf || cyc != e.cyc) begin
               errors++;
               $display("FAIL b_column got cyc=%0d data=%h cl=%b rf=%b required cyc=%0d data=%h cl=%b rf=%b",
                        cyc, ifb.data_out, ifb.col_last, ifb.row_first, e.cyc, e.d, e.cl, e.rf);
            end
         end
      end else begin
         checks++;
         if (ifb.col_last !== 1'b0 || ifb.row_first !== 1'b0) begin
            errors++;
            $display("FAIL b_idle_flags cyc=%0d got cl=%b rf=%b required 0 0", cyc, ifb.col_last, ifb.row_first);
         end
         if (qb.size() != 0 && qb[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL b_missing cyc=%0d got no valid_out required data=%h", cyc, qb[0].d);
            void'(qb.pop_front());
         end
      end
   endtask

   // Drive one cycle of inputs and update the frame model; columns are built from full pixel history.
   task automatic drive(input logic c, input logic [9:0] l, input logic v, input logic [31:0] d);
      exp_t        e;
      logic [31:0] w;
      tick();
      cfg_load = c;
      row_len  = l;
      valid_in = v;
      data_in  = d;
      if (!rstn) return;
      if (c) begin
         len_q = (l < 10'd2 || l > 10'd320) ? 320 : int'(l);
         m_col = 0;
         m_row = 0;
         fr.delete();
      end else if (v) begin
         fr[m_row * len_q + m_col] = d;
         if (m_row >= 2) begin
            e.d = '0;
            for (int j = 0; j < 3; j++) begin
               w = fr[(m_row - j) * len_q + m_col];
               e.d[j*PA +: PA] = w[PA-1:0];
            end
            e.cl  = (m_col == len_q - 1);
            e.rf  = (m_row == 2);
            e.cyc = cyc + 2;
            qa.push_back(e);
         end
         if (m_row >= 4) begin
            e.d = '0;
            for (int j = 0; j < 5; j++) begin
               w = fr[(m_row - j) * len_q + m_col];
               e.d[j*PB +: PB] = w;
            end
            e.cl  = (m_col == len_q - 1);
            e.rf  = (m_row == 4);
            e.cyc = cyc + 2;
            qb.push_back(e);
         end
         if (m_col == len_q - 1) begin
            m_col = 0;
            m_row++;
         end else m_col++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, row_len, 1'b0, 32'h0);
   endtask

   task automatic check_drained(input string tag);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL %s_drained got pending a=%0d b=%0d required 0 0", tag, qa.size(), qb.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (ifa.data_out !== '0 || ifa.valid_out !== 1'b0 || ifa.col_last !== 1'b0 || ifa.row_first !== 1'b0) begin
         errors++;
         $display("FAIL reset_a got data=%h v=%b cl=%b rf=%b required all 0", ifa.data_out, ifa.valid_out, ifa.col_last, ifa.row_first);
      end
      checks++;
      if (ifb.data_out !== '0 || ifb.valid_out !== 1'b0 || ifb.col_last !== 1'b0 || ifb.row_first !== 1'b0) begin
         errors++;
         $display("FAIL reset_b got data=%h v=%b cl=%b rf=%b required all 0", ifb.data_out, ifb.valid_out, ifb.col_last, ifb.row_first);
      end
      rstn = 1'b1;
      idle(2);
   endtask

   task automatic test_warmup();
      logic [7:0] b;
      drive(1'b1, 10'd4, 1'b0, 32'h0);
      for (int i = 0; i < 12; i++) begin
         b = 8'(i);
         drive(1'b0, 10'd4, 1'b1, {4{b}});
         if (i == 10) begin
            checks++;
            if (ifa.valid_out !== 1'b1 || ifa.data_out !== 48'h0000_0404_0808 || ifa.row_first !== 1'b1) begin
               errors++;
               $display("FAIL warmup_pix8 got v=%b data=%h rf=%b required 1 000004040808 1", ifa.valid_out, ifa.data_out, ifa.row_first);
            end
         end
      end
      idle(2);
      checks++;
      if (ifa.valid_out !== 1'b1 || ifa.col_last !== 1'b1 || ifa.data_out !== 48'h0303_0707_0b0b) begin
         errors++;
         $display("FAIL warmup_pix11 got v=%b cl=%b data=%h required 1 1 030307070b0b", ifa.valid_out, ifa.col_last, ifa.data_out);
      end
      idle(3);
      check_drained("warmup");
   endtask

   task automatic test_gaps();
      drive(1'b1, 10'd6, 1'b0, 32'h0);
      for (int i = 0; i < 36; i++) begin
         drive(1'b0, 10'd6, 1'b1, $urandom);
         idle($urandom_range(0, 3));
      end
      idle(3);
      check_drained("gaps");
   endtask

   task automatic test_wrap_saturate();
      int na = 0;
      int nc = 0;
      int nf = 0;
      idle(3);
      drive(1'b1, 10'd320, 1'b0, 32'h0);
      for (int i = 0; i < 1603; i++) begin
         drive(1'b0, 10'd320, i < 1600, $urandom);
         if (ifa.valid_out === 1'b1) na++;
         if (ifa.col_last === 1'b1) nc++;
         if (ifa.row_first === 1'b1) nf++;
      end
      checks++;
      if (na != 960 || nc != 3 || nf != 320) begin
         errors++;
         $display("FAIL wrap_counts got out=%0d last=%0d first=%0d required 960 3 320", na, nc, nf);
      end
      check_drained("wrap");
   endtask

   task automatic test_reconfigure();
      int na = 0;
      drive(1'b1, 10'd4, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++) drive(1'b0, 10'd4, 1'b1, $urandom);
      idle(2);
      drive(1'b1, 10'd5, 1'b1, $urandom);
      for (int i = 0; i < 18; i++) begin
         drive(1'b0, 10'd5, i < 15, $urandom);
         if (ifa.valid_out === 1'b1) na++;
      end
      checks++;
      if (na != 5) begin
         errors++;
         $display("FAIL reconfig_count got %0d outputs required 5", na);
      end
      check_drained("reconfig");
   endtask

   task automatic test_reset_mid_row();
      int na = 0;
      drive(1'b1, 10'd4, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++) drive(1'b0, 10'd4, 1'b1, $urandom);
      tick();
      #2;
      rstn = 1'b0;
      cfg_load = 1'b0;
      valid_in = 1'b0;
      qa.delete();
      qb.delete();
      fr.delete();
      len_q = 320;
      m_col = 0;
      m_row = 0;
      @(posedge clk);
      #1;
      checks++;
      if (ifa.data_out !== '0 || ifa.valid_out !== 1'b0 || ifb.data_out !== '0 || ifb.valid_out !== 1'b0 ||
          ifa.col_last !== 1'b0 || ifa.row_first !== 1'b0 || ifb.col_last !== 1'b0 || ifb.row_first !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got a=%h/%b b=%h/%b required all 0", ifa.data_out, ifa.valid_out, ifb.data_out, ifb.valid_out);
      end
      @(negedge clk);
      rstn = 1'b1;
      drive(1'b1, 10'd4, 1'b0, 32'h0);
      for (int i = 0; i < 15; i++) begin
         drive(1'b0, 10'd4, i < 12, $urandom);
         if (ifa.valid_out === 1'b1) na++;
      end
      checks++;
      if (na != 4) begin
         errors++;
         $display("FAIL reset_rewarm got %0d outputs required 4", na);
      end
      check_drained("reset_mid");
   endtask

   task automatic test_clamp();
      int na = 0;
      int nc = 0;
      drive(1'b1, 10'd0, 1'b0, 32'h0);
      for (int i = 0; i < 653; i++) begin
         drive(1'b0, 10'd0, i < 650, $urandom);
         if (ifa.valid_out === 1'b1) na++;
         if (ifa.col_last === 1'b1) nc++;
      end
      checks++;
      if (na != 10 || nc != 0) begin
         errors++;
         $display("FAIL clamp_counts got out=%0d last=%0d required 10 0", na, nc);
      end
      check_drained("clamp");
   endtask

   task automatic test_scaling();
      int nb = 0;
      for (int f = 0; f < 3; f++) begin
         drive(1'b1, 10'd7, 1'b0, 32'h0);
         for (int i = 0; i < 45; i++) begin
            drive(1'b0, 10'd7, i < 42, $urandom);
            if (ifb.valid_out === 1'b1) nb++;
         end
      end
      checks++;
      if (nb != 42) begin
         errors++;
         $display("FAIL scaling_count got %0d outputs required 42", nb);
      end
      check_drained("scaling");
   endtask

   initial begin
      test_reset();
      test_warmup();
      test_gaps();
      test_wrap_saturate();
      test_reconfigure();
      test_reset_mid_row();
      test_clamp();
      test_scaling();
      idle(4);
      check_drained("final");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
